// File: rtl/jtdd_rom_arb_pkg.sv
// Shared types and constants for the three-way ROM arbiter: FSM states, grant indices, default SDRAM word offsets.
// Pure declarations, no logic, so there is no latency and no backpressure.
package jtdd_rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef logic [1:0] grant_t;

    localparam grant_t MAIN = 2'd0;
    localparam grant_t SND  = 2'd1;
    localparam grant_t MCU  = 2'd2;

    localparam logic [21:0] MAIN_OFFSET_DEF = 22'h000000;
    localparam logic [21:0] SND_OFFSET_DEF  = 22'h020000;
    localparam logic [21:0] MCU_OFFSET_DEF  = 22'h028000;

    localparam int TAG_W = 17;

    // Rotation order used by the round-robin search: main -> snd -> mcu -> main.
    function automatic grant_t next_grant(input grant_t g);
        return (g == MCU) ? MAIN : grant_t'(g + 2'd1);
    endfunction

endpackage

// File: rtl/jtdd_rom_slot.sv
// One-word ROM cache for a single 8-bit requester: zero-cycle hit, ok/dout combinational from registers.
// A miss raises pending until the arbiter strobes fill; the requester stalls on its ok line meanwhile.
module jtdd_rom_slot
    import jtdd_rom_arb_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-2:0] fill_tag,
    input  logic [15:0]   fill_data,
    output logic          ok,
    output logic [7:0]    dout,
    output logic          pending
);

    logic          valid_q, valid_d;
    logic [AW-2:0] tag_q,   tag_d;
    logic [15:0]   word_q,  word_d;
    logic          hit;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        word_d  = word_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            word_d  = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            word_q  <= word_d;
        end
    end

    assign hit     = cs & valid_q & (tag_q == addr[AW-1:1]);
    assign ok      = hit;
    assign dout    = addr[0] ? word_q[15:8] : word_q[7:0];
    assign pending = cs & ~hit;

endmodule

// File: rtl/jtdd_rom_arb.sv
// Shares one 16-bit SDRAM read port among main/snd/mcu ROM requesters; hits take 0 cycles, misses >=3 + SDRAM latency.
// One outstanding request; sdram_req held until sdram_ack. JTDD_ROMARB_RR_EN selects round-robin instead of main>snd>mcu.
module jtdd_rom_arb
    import jtdd_rom_arb_pkg::*;
#(
    parameter logic [21:0] MAIN_OFFSET = MAIN_OFFSET_DEF,
    parameter logic [21:0] SND_OFFSET  = SND_OFFSET_DEF,
    parameter logic [21:0] MCU_OFFSET  = MCU_OFFSET_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic [17:0] main_addr,
    output logic [7:0]  main_dout,
    output logic        main_ok,
    input  logic        snd_cs,
    input  logic [14:0] snd_addr,
    output logic [7:0]  snd_dout,
    output logic        snd_ok,
    input  logic        mcu_cs,
    input  logic [13:0] mcu_addr,
    output logic [7:0]  mcu_dout,
    output logic        mcu_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_data
);

    state_t             state_q,      state_d;
    grant_t             grant_q,      grant_d;
    logic [TAG_W-1:0]   tag_q,        tag_d;
    logic               sdram_req_q,  sdram_req_d;
    logic [21:0]        sdram_addr_q, sdram_addr_d;

    logic [2:0]         pend;
    logic               fill_any;
    grant_t             pick;
    logic [TAG_W-1:0]   pick_tag;
    logic [21:0]        pick_addr;

    logic               main_pend, snd_pend, mcu_pend;
    logic               main_fill, snd_fill, mcu_fill;

`ifdef JTDD_ROMARB_RR_EN
    grant_t             last_q, last_d;
    grant_t             cand;
    logic               found;
`endif

    jtdd_rom_slot #(.AW(18)) u_main_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (main_cs),
        .addr      (main_addr),
        .fill      (main_fill),
        .fill_tag  (tag_q[16:0]),
        .fill_data (sdram_data),
        .ok        (main_ok),
        .dout      (main_dout),
        .pending   (main_pend)
    );

    jtdd_rom_slot #(.AW(15)) u_snd_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (snd_cs),
        .addr      (snd_addr),
        .fill      (snd_fill),
        .fill_tag  (tag_q[13:0]),
        .fill_data (sdram_data),
        .ok        (snd_ok),
        .dout      (snd_dout),
        .pending   (snd_pend)
    );

    jtdd_rom_slot #(.AW(14)) u_mcu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (mcu_cs),
        .addr      (mcu_addr),
        .fill      (mcu_fill),
        .fill_tag  (tag_q[12:0]),
        .fill_data (sdram_data),
        .ok        (mcu_ok),
        .dout      (mcu_dout),
        .pending   (mcu_pend)
    );

    assign pend = {mcu_pend, snd_pend, main_pend};

    // Grant selection; only consumed while IDLE.
    always_comb begin
        pick = MAIN;
`ifdef JTDD_ROMARB_RR_EN
        cand  = next_grant(last_q);
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = next_grant(cand);
        end
`else
        if (pend[MAIN]) begin
            pick = MAIN;
        end else if (pend[SND]) begin
            pick = SND;
        end else if (pend[MCU]) begin
            pick = MCU;
        end
`endif
        case (pick)
            SND: begin
                pick_tag  = {3'b000, snd_addr[14:1]};
                pick_addr = SND_OFFSET + {8'd0, snd_addr[14:1]};
            end
            MCU: begin
                pick_tag  = {4'b0000, mcu_addr[13:1]};
                pick_addr = MCU_OFFSET + {9'd0, mcu_addr[13:1]};
            end
            default: begin
                pick_tag  = main_addr[17:1];
                pick_addr = MAIN_OFFSET + {5'd0, main_addr[17:1]};
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        tag_d        = tag_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        fill_any     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    grant_d      = pick;
                    tag_d        = pick_tag;
                    sdram_addr_d = pick_addr;
                    sdram_req_d  = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    // Data may come back with the accept; skip WAIT in that case.
                    if (sdram_rdy) begin
                        fill_any = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (sdram_rdy) begin
                    fill_any = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                sdram_req_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

`ifdef JTDD_ROMARB_RR_EN
    assign last_d = (state_q == IDLE && |pend) ? pick : last_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= MAIN;
            tag_q        <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
`ifdef JTDD_ROMARB_RR_EN
            last_q       <= MCU;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            tag_q        <= tag_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
`ifdef JTDD_ROMARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    assign main_fill  = fill_any & (grant_q == MAIN);
    assign snd_fill   = fill_any & (grant_q == SND);
    assign mcu_fill   = fill_any & (grant_q == MCU);

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: SDRAM responder with programmable ack/rdy delays plus a cache/arbitration model.
module tb_jtdd_rom_arb;

    logic        clk;
    logic        rst_n;
    logic        tcs [3];
    logic [17:0] tad [3];

    logic        main_cs, snd_cs, mcu_cs;
    logic [17:0] main_addr;
    logic [14:0] snd_addr;
    logic [13:0] mcu_addr;
    logic [7:0]  main_dout, snd_dout, mcu_dout;
    logic        main_ok, snd_ok, mcu_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, sdram_rdy;
    logic [15:0] sdram_data;

    logic [2:0]  okv;
    logic [7:0]  dv [3];

    int n_cmp = 0;
    int n_err = 0;
    int ack_dly = 1;
    int rdy_dly = 1;
    int model_last = 2;

    logic [21:0] req_log [$];
    logic [21:0] fill_log [$];
    logic        mv [3];
    logic [21:0] mt [3];

    assign main_cs   = tcs[0];
    assign snd_cs    = tcs[1];
    assign mcu_cs    = tcs[2];
    assign main_addr = tad[0];
    assign snd_addr  = tad[1][14:0];
    assign mcu_addr  = tad[2][13:0];
    assign okv       = {mcu_ok, snd_ok, main_ok};
    assign dv[0]     = main_dout;
    assign dv[1]     = snd_dout;
    assign dv[2]     = mcu_dout;

    jtdd_rom_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .main_cs    (main_cs),
        .main_addr  (main_addr),
        .main_dout  (main_dout),
        .main_ok    (main_ok),
        .snd_cs     (snd_cs),
        .snd_addr   (snd_addr),
        .snd_dout   (snd_dout),
        .snd_ok     (snd_ok),
        .mcu_cs     (mcu_cs),
        .mcu_addr   (mcu_addr),
        .mcu_dout   (mcu_dout),
        .mcu_ok     (mcu_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_data (sdram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [21:0] a);
        logic [15:0] h;
        if (a == 22'h000008) return 16'hBEEF;
        h = a[15:0] * 16'h9E37;
        return h ^ {a[21:16], a[21:12]} ^ 16'h1234;
    endfunction

    function automatic logic [21:0] exp_wa(input int r, input logic [17:0] a);
        case (r)
            0:       return 22'h000000 + {5'd0, a[17:1]};
            1:       return 22'h020000 + {8'd0, a[14:1]};
            default: return 22'h028000 + {9'd0, a[13:1]};
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int r, input logic [17:0] a);
        logic [15:0] w;
        w = mem_word(exp_wa(r, a));
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic int region(input logic [21:0] wa);
        if (wa < 22'h020000) return 0;
        if (wa < 22'h028000) return 1;
        return 2;
    endfunction

    function automatic int arb_pick(input logic [2:0] mask, input int last);
`ifdef JTDD_ROMARB_RR_EN
        for (int k = 1; k <= 3; k++) if (mask[(last + k) % 3]) return (last + k) % 3;
`else
        for (int c = 0; c < 3; c++) if (mask[c]) return c;
        if (last > 99) return 0;
`endif
        return 0;
    endfunction

    // SDRAM side: ack after ack_dly cycles, data rdy_dly cycles after the ack (0 = same cycle).
    initial begin : sdram_model
        logic [21:0] a;
        sdram_ack  = 1'b0;
        sdram_rdy  = 1'b0;
        sdram_data = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && sdram_req === 1'b1) begin
                a = sdram_addr;
                repeat (ack_dly) @(negedge clk);
                sdram_ack = 1'b1;
                req_log.push_back(a);
                if (rdy_dly == 0) begin
                    sdram_rdy  = 1'b1;
                    sdram_data = mem_word(a);
                end
                @(negedge clk);
                sdram_ack = 1'b0;
                if (rdy_dly == 0) begin
                    sdram_rdy = 1'b0;
                    fill_log.push_back(a);
                end else begin
                    repeat (rdy_dly - 1) @(negedge clk);
                    sdram_rdy  = 1'b1;
                    sdram_data = mem_word(a);
                    @(negedge clk);
                    sdram_rdy = 1'b0;
                    fill_log.push_back(a);
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tcs[r] = 1'b1;
            tad[r] = 18'(10 * r + 10);
        end
        repeat (3) tick;
        n_cmp++; if (okv !== 3'b000) begin n_err++; $display("FAIL rst_ok got=%b exp=000", okv); end
        n_cmp++; if ({dv[0], dv[1], dv[2]} !== 24'h0) begin n_err++; $display("FAIL rst_dout got=%h exp=000000", {dv[0], dv[1], dv[2]}); end
        n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", sdram_req); end
        n_cmp++; if (sdram_addr !== 22'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=000000", sdram_addr); end
        for (int r = 0; r < 3; r++) tcs[r] = 1'b0;
        rst_n = 1'b1;
        tick; tick;
        n_cmp++; if (okv !== 3'b000 || sdram_req !== 1'b0) begin n_err++; $display("FAIL post_rst got ok=%b req=%b exp ok=000 req=0", okv, sdram_req); end
        model_last = 2;
    endtask

    task automatic test_main_fill;
        int n0, rdy_t, ok_t;
        ack_dly = 2; rdy_dly = 2;
        n0 = req_log.size();
        tad[0] = 18'h00010; tcs[0] = 1'b1;
        #1;
        n_cmp++; if (main_ok !== 1'b0) begin n_err++; $display("FAIL main_miss_ok got=%b exp=0", main_ok); end
        rdy_t = -1; ok_t = -1;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (sdram_rdy === 1'b1 && rdy_t < 0) rdy_t = c;
            if (main_ok === 1'b1) begin ok_t = c; break; end
        end
        n_cmp++;
        if (ok_t < 0) begin
            n_err++; $display("FAIL main_fill_timeout got=no_ok exp=ok");
        end else begin
            n_cmp++; if (ok_t !== rdy_t + 1) begin n_err++; $display("FAIL main_ok_timing got=%0d exp=%0d", ok_t, rdy_t + 1); end
            n_cmp++; if (ok_t < 3) begin n_err++; $display("FAIL main_latency got=%0d exp>=3", ok_t); end
        end
        n_cmp++; if (req_log.size() !== n0 + 1 || req_log[n0] !== 22'h000008) begin n_err++; $display("FAIL main_sdram_addr got=%h exp=000008", (req_log.size() > n0) ? req_log[n0] : 22'h3FFFFF); end
        n_cmp++; if (main_dout !== 8'hEF) begin n_err++; $display("FAIL main_dout_lo got=%h exp=EF", main_dout); end
        model_last = 0;
        tad[0] = 18'h00011;
        #1;
        n_cmp++; if (main_ok !== 1'b1 || main_dout !== 8'hBE) begin n_err++; $display("FAIL main_hit_hi got ok=%b d=%h exp ok=1 d=BE", main_ok, main_dout); end
        n_cmp++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL main_hit_noreq got=%b exp=0", sdram_req); end
        repeat (4) tick;
        n_cmp++; if (req_log.size() !== n0 + 1) begin n_err++; $display("FAIL main_hit_refetch got=%0d exp=%0d", req_log.size(), n0 + 1); end
        tcs[0] = 1'b0;
        tick;
    endtask

    task automatic test_snd;
        int n0;
        logic other_ok, done;
        ack_dly = 1; rdy_dly = 3;
        n0 = req_log.size();
        tad[1] = 18'h00004; tcs[1] = 1'b1;
        other_ok = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick;
            if (main_ok !== 1'b0 || mcu_ok !== 1'b0) other_ok = 1'b1;
            if (snd_ok === 1'b1) done = 1'b1;
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL snd_timeout got=no_ok exp=ok"); end
        n_cmp++; if (other_ok !== 1'b0) begin n_err++; $display("FAIL snd_other_ok got=%b exp=0", other_ok); end
        n_cmp++; if (req_log.size() !== n0 + 1 || req_log[n0] !== 22'h020002) begin n_err++; $display("FAIL snd_sdram_addr got=%h exp=020002", (req_log.size() > n0) ? req_log[n0] : 22'h3FFFFF); end
        n_cmp++; if (snd_dout !== exp_byte(1, 18'h4)) begin n_err++; $display("FAIL snd_dout got=%h exp=%h", snd_dout, exp_byte(1, 18'h4)); end
        model_last = 1;
        tcs[1] = 1'b0;
        tick;
    endtask

    task automatic test_priority;
        int n0, p;
        logic [2:0] mask;
        logic done;
        ack_dly = 1; rdy_dly = 2;
        n0 = req_log.size();
        for (int r = 0; r < 3; r++) begin tad[r] = 18'h00100; tcs[r] = 1'b1; end
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            tick;
            if (okv === 3'b111) done = 1'b1;
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL prio_timeout got=%b exp=111", okv); end
        n_cmp++; if (req_log.size() !== n0 + 3) begin n_err++; $display("FAIL prio_count got=%0d exp=%0d", req_log.size() - n0, 3); end
        mask = 3'b111;
        for (int i = 0; i < 3; i++) begin
            p = arb_pick(mask, model_last);
            mask[p] = 1'b0;
            model_last = p;
            n_cmp++;
            if (req_log.size() <= n0 + i || req_log[n0 + i] !== exp_wa(p, tad[p])) begin
                n_err++; $display("FAIL prio_order%0d got=%h exp=%h", i, (req_log.size() > n0 + i) ? req_log[n0 + i] : 22'h3FFFFF, exp_wa(p, tad[p]));
            end
        end
        for (int r = 0; r < 3; r++) begin
            n_cmp++; if (dv[r] !== exp_byte(r, tad[r])) begin n_err++; $display("FAIL prio_dout%0d got=%h exp=%h", r, dv[r], exp_byte(r, tad[r])); end
            tcs[r] = 1'b0;
        end
        tick;
    endtask

    task automatic test_ack_rdy_same;
        int n0, r1, r2;
        logic seen, done;
        ack_dly = 0; rdy_dly = 0;
        tad[0] = 18'h00200; tad[1] = 18'h00200;
        r1 = arb_pick(3'b011, model_last);
        r2 = (r1 == 0) ? 1 : 0;
        n0 = req_log.size();
        tcs[0] = 1'b1; tcs[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick;
            if (req_log.size() > n0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL same_ack_timeout got=no_req exp=req"); end
        tick;
        n_cmp++; if (sdram_req !== 1'b0 || okv[r1] !== 1'b1) begin n_err++; $display("FAIL same_fill got req=%b ok=%b exp req=0 ok=1", sdram_req, okv[r1]); end
        n_cmp++; if (dv[r1] !== exp_byte(r1, tad[r1])) begin n_err++; $display("FAIL same_dout got=%h exp=%h", dv[r1], exp_byte(r1, tad[r1])); end
        tick;
        n_cmp++; if (sdram_req !== 1'b1 || sdram_addr !== exp_wa(r2, tad[r2])) begin n_err++; $display("FAIL same_next_req got req=%b a=%h exp req=1 a=%h", sdram_req, sdram_addr, exp_wa(r2, tad[r2])); end
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick;
            if (okv[r2] === 1'b1) done = 1'b1;
        end
        n_cmp++; if (!done || dv[r2] !== exp_byte(r2, tad[r2])) begin n_err++; $display("FAIL same_second got ok=%b d=%h exp ok=1 d=%h", done, dv[r2], exp_byte(r2, tad[r2])); end
        model_last = r2;
        tcs[0] = 1'b0; tcs[1] = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int n0, n1;
        logic seen, quiet_bad, done;
        ack_dly = 1; rdy_dly = 6;
        n0 = req_log.size();
        tad[0] = 18'h00300; tcs[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick;
            if (req_log.size() > n0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rmid_ack_timeout got=no_req exp=req"); end
        tick;
        rst_n = 1'b0; tcs[0] = 1'b0;
        tick; tick;
        n_cmp++; if (sdram_req !== 1'b0 || sdram_addr !== 22'h0 || okv !== 3'b000) begin n_err++; $display("FAIL rmid_in_rst got req=%b a=%h ok=%b exp 0/0/000", sdram_req, sdram_addr, okv); end
        rst_n = 1'b1;
        quiet_bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (okv !== 3'b000 || sdram_req !== 1'b0) quiet_bad = 1'b1;
        end
        n_cmp++; if (quiet_bad) begin n_err++; $display("FAIL rmid_quiet got=active exp=idle"); end
        fill_log.delete();
        model_last = 2;
        n1 = req_log.size();
        tcs[0] = 1'b1;
        #1;
        n_cmp++; if (main_ok !== 1'b0) begin n_err++; $display("FAIL rmid_stale_hit got=%b exp=0", main_ok); end
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick;
            if (main_ok === 1'b1) done = 1'b1;
        end
        n_cmp++; if (!done || req_log.size() !== n1 + 1 || req_log[n1] !== exp_wa(0, tad[0])) begin n_err++; $display("FAIL rmid_refetch got ok=%b n=%0d exp ok=1 n=%0d", done, req_log.size() - n1, 1); end
        n_cmp++; if (main_dout !== exp_byte(0, tad[0])) begin n_err++; $display("FAIL rmid_dout got=%h exp=%h", main_dout, exp_byte(0, tad[0])); end
        model_last = 0;
        tcs[0] = 1'b0;
        tick;
    endtask

    task automatic test_random;
        logic chg, done, e_ok;
        logic [21:0] wa;
        rst_n = 1'b0;
        for (int r = 0; r < 3; r++) tcs[r] = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        req_log.delete(); fill_log.delete();
        for (int r = 0; r < 3; r++) begin mv[r] = 1'b0; mt[r] = 22'h0; end
        for (int it = 0; it < 150; it++) begin
            ack_dly = $urandom_range(0, 3);
            rdy_dly = $urandom_range(0, 4);
            for (int r = 0; r < 3; r++) begin
                tcs[r] = ($urandom_range(0, 3) != 0);
                tad[r] = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 7));
            end
            chg = ($urandom_range(0, 3) == 0);
            done = 1'b0;
            for (int c = 0; c < 120 && !done; c++) begin
                if (chg && c == 3) tad[0] = 18'($urandom_range(0, 15));
                #1;
                while (fill_log.size() > 0) begin
                    wa = fill_log.pop_front();
                    mv[region(wa)] = 1'b1;
                    mt[region(wa)] = wa;
                end
                done = 1'b1;
                for (int r = 0; r < 3; r++) begin
                    e_ok = tcs[r] && mv[r] && (mt[r] == exp_wa(r, tad[r]));
                    n_cmp++;
                    if (okv[r] !== e_ok) begin
                        n_err++; $display("FAIL rnd_ok it=%0d r=%0d got=%b exp=%b", it, r, okv[r], e_ok);
                    end else if (e_ok) begin
                        n_cmp++;
                        if (dv[r] !== exp_byte(r, tad[r])) begin n_err++; $display("FAIL rnd_dout it=%0d r=%0d got=%h exp=%h", it, r, dv[r], exp_byte(r, tad[r])); end
                    end
                    if (tcs[r] && okv[r] !== 1'b1) done = 1'b0;
                end
                if (!done) @(negedge clk);
            end
            if (!done) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_timeout it=%0d got ok=%b exp all requesters served", it, okv);
            end
        end
        for (int r = 0; r < 3; r++) tcs[r] = 1'b0;
        tick;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main_seq
        rst_n = 1'b0;
        for (int r = 0; r < 3; r++) begin tcs[r] = 1'b0; tad[r] = 18'h0; end
        test_reset;
        test_main_fill;
        test_snd;
        test_priority;
        test_ack_rdy_same;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtdd_rom_arb.md
Name: jtdd_rom_arb

Overview:
- Shares one 16-bit SDRAM read port among three 8-bit ROM requesters: main 6809, sound CPU and MCU.
- Each requester presents a chip select and a byte address, and waits on its own `*_ok` line, the same protocol the main CPU already uses with `rom_cs`/`rom_addr`/`rom_ok`.
- A one-word cache per requester serves repeated hits in the same 16-bit word with zero latency.
- Sits between the CPU blocks and the SDRAM controller in the game top level.

Parameters:
- MAIN_OFFSET, 22'h000000, SDRAM word offset of main ROM region.
- SND_OFFSET, 22'h020000, SDRAM word offset of sound ROM region.
- MCU_OFFSET, 22'h028000, SDRAM word offset of MCU ROM region.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- main_cs  in  1  main CPU ROM access.
- main_addr  in  18  main byte address.
- main_dout  out  8  main data.
- main_ok  out  1  main data valid.
- snd_cs  in  1  sound ROM access.
- snd_addr  in  15  sound byte address.
- snd_dout  out  8  sound data.
- snd_ok  out  1  sound data valid.
- mcu_cs  in  1  MCU ROM access.
- mcu_addr  in  14  MCU byte address.
- mcu_dout  out  8  MCU data.
- mcu_ok  out  1  MCU data valid.
- sdram_req  out  1  read request, held until acknowledged.
- sdram_addr  out  22  word address.
- sdram_ack  in  1  one-cycle request accept.
- sdram_rdy  in  1  one-cycle data valid.
- sdram_data  in  16  read word.

Behaviour:
- Clock and reset:
  - Clock is `clk`. Reset is `rst_n`, synchronous and active-low: sampled on the rising edge of `clk`, active when 0.
  - Reset clears all cache valid bits, sets state IDLE and drives `sdram_req`=0 and `sdram_addr`=0.
  - During and after reset every `*_ok`=0 and every `*_dout`=8'h00 until the first fill.
- Cache:
  - Per requester: tag = addr[N-1:1], 16-bit word, valid bit.
  - hit = cs & valid & (tag == addr[N-1:1]).
  - `x_ok` = hit, combinational from registers, so a hit has 0-cycle latency.
  - `x_dout` = addr[0] ? word[15:8] : word[7:0].
- Miss: cs & !hit marks the requester pending.
- State machine:
  - IDLE:
    - If any requester is pending, grant one by fixed priority main > snd > mcu.
    - Latch grant index and the word address: OFFSET + addr[N-1:1], zero-extended to 22 bits, wrapping modulo 2^22.
    - Go to REQ.
  - REQ:
    - `sdram_req`=1; `sdram_addr` is stable.
    - On `sdram_ack`, deassert `sdram_req` next cycle and go to WAIT.
    - If `sdram_rdy` arrives in the same cycle as `sdram_ack`, fill immediately and go to IDLE.
  - WAIT:
    - On `sdram_rdy`, write `sdram_data` to the granted cache, set tag to the latched address and valid=1, then go to IDLE.
    - The requester sees `ok` the cycle after the fill.
- Miss latency: at least 3 cycles (IDLE→REQ, ack, rdy) plus SDRAM latency.
- Boundary conditions:
  - Requester changes address or drops cs mid-fetch: the fetch completes and the cache fills with the latched address. A new address is then a miss and is re-arbitrated from IDLE.
  - `sdram_rdy` outside WAIT/REQ is ignored.
  - `sdram_ack` outside REQ is ignored.
  - Only one outstanding SDRAM request at a time.
  - Reset mid-fetch drops the transaction; a late `sdram_rdy` after reset is ignored.
- No cache invalidation other than reset; ROM is read-only.

Optional Feature:
- Macro: JTDD_ROMARB_RR_EN.
- Defined: IDLE grants round-robin. Search starts at the requester after the last granted one (main→snd→mcu→main); a 2-bit last-grant register resets to mcu so main wins first.
- Undefined: fixed priority main > snd > mcu, and the last-grant register is not instantiated.

Decomposition:
- Shared package jtdd_rom_arb_pkg holds:
  - state enum IDLE/REQ/WAIT;
  - grant index constants MAIN=0, SND=1, MCU=2;
  - default offset constants.
- One natural sub-module, jtdd_rom_slot: parameterised on address width. Holds tag/word/valid, produces hit/ok/dout/pending, and accepts a fill strobe. It is instantiated three times.

Test Plan:
- main_cs=1, main_addr=18'h00010 after reset; ack after 2 cycles, rdy after 4 with data 16'hBEEF → sdram_addr=22'h000008, main_dout=8'hEF, main_ok=1 the cycle after rdy; main_addr=18'h00011 then gives 8'hBE and ok in the same cycle with no sdram_req.
- snd_cs with snd_addr=15'h0004 → sdram_addr=22'h020002; main_ok and mcu_ok stay 0.
- main, snd and mcu all miss in the same cycle, fixed priority → grants main, snd, mcu in that order, three separate sdram_req phases.
- Same stimulus with JTDD_ROMARB_RR_EN, main re-missing continuously → order main, snd, mcu, main; no requester waits more than two grants.
- sdram_ack and sdram_rdy in the same cycle → fill occurs, state returns to IDLE, next pending request is issued within 1 cycle.
- rst_n=0 during WAIT, rdy arrives after release → no fill, all ok=0, sdram_req=0; the next miss re-fetches.
